// File: rtl/c3lib_ckmux4_sel_seq.sv
// Select sequencer for the 4:1 LVT clock mux: gates the mux output off, moves
// s1/s0, waits for the mux to settle, then re-enables the gate.
module c3lib_ckmux4_sel_seq #(
  parameter int unsigned GATE_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CNT_W      = 4,
  parameter logic [1:0]  RST_SEL    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_req_vld,
  input  logic [1:0] sel_req,
  input  logic       sel_freeze,
  output logic       sel_req_rdy,
  output logic       s0,
  output logic       s1,
  output logic       ck_gate_en,
  output logic       busy,
  output logic       sel_done
);

  typedef enum logic [1:0] {IDLE, GATE_OFF, SETTLE, DONE} state_t;

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_sel,   w_sel_nxt;
  logic [1:0]       r_req,   w_req_nxt;
  logic             w_accept;

  assign sel_req_rdy = (r_state == IDLE) & ~sel_freeze;
  assign w_accept    = sel_req_vld & sel_req_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= RST_SEL;
      r_req   <= RST_SEL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Selects only move on the GATE_OFF->SETTLE edge, while the gate is off.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_req_nxt   = r_req;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_req_nxt = sel_req;
          if (sel_req == r_sel) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = GATE_OFF;
            w_cnt_nxt   = GATE_LD;
          end
        end
      end
      GATE_OFF: begin
        if (r_cnt == '0) begin
          w_state_nxt = SETTLE;
          w_sel_nxt   = r_req;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s1         = r_sel[1];
  assign s0         = r_sel[0];
  assign ck_gate_en = ~((r_state == GATE_OFF) | (r_state == SETTLE));
  assign busy       = (r_state == GATE_OFF) | (r_state == SETTLE);
  assign sel_done   = (r_state == DONE);

endmodule
